// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types, sizes and lane helper for the vector memory unit
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

    localparam int LANES  = 8;
    localparam int WORD_W = 32;
    localparam int VEC_W  = LANES * WORD_W;

    // Word i of a vector; lane 0 sits in the least significant bits.
    function automatic logic [WORD_W-1:0] lane_sel(
        input logic [VEC_W-1:0]         vec,
        input logic [$clog2(LANES)-1:0] i
    );
        return vec[i*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/vlane_gather.sv
// rtl/vlane_gather.sv - vector register with bulk load and per-lane word write
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (clears the register)
//   load_all    overwrite the whole vector with load_data
//   load_data   full-width vector value
//   lane_we     write lane_data into lane lane_idx (load_all has priority)
//   lane_idx    lane selector
//   lane_data   one word
//   q           current register contents
module vlane_gather
    import mem_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_all,
    input  logic [VEC_W-1:0]         load_data,
    input  logic                     lane_we,
    input  logic [$clog2(LANES)-1:0] lane_idx,
    input  logic [WORD_W-1:0]        lane_data,
    output logic [VEC_W-1:0]         q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load_all) begin
            q <= load_data;
        end else if (lane_we) begin
            q[lane_idx*WORD_W +: WORD_W] <= lane_data;
        end
    end

endmodule

// File: rtl/vector_mem_unit.sv
// rtl/vector_mem_unit.sv - memory-stage unit serializing vector/scalar loads and stores into word accesses
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 request pulse, taken only while idle
//   is_store, is_vector   access kind, sampled with start
//   addr                  base byte address (low two bits ignored)
//   store_vec, store_word store data for vector / scalar stores
//   busy, done            stall while not idle; one-cycle completion pulse
//   load_vec, load_word   gathered load result (load_word = lane 0)
//   mem_req .. mem_rdata  single-word memory port with mem_ready handshake
module vector_mem_unit #(
    parameter int LANES  = 8,
    parameter int WORD_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    is_store,
    input  logic                    is_vector,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [LANES*WORD_W-1:0] store_vec,
    input  logic [WORD_W-1:0]       store_word,
    output logic                    busy,
    output logic                    done,
    output logic [LANES*WORD_W-1:0] load_vec,
    output logic [WORD_W-1:0]       load_word,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [WORD_W-1:0]       mem_wdata,
    input  logic                    mem_ready,
    input  logic [WORD_W-1:0]       mem_rdata
);

    import mem_pkg::*;

    localparam int IW = $clog2(LANES);

    mem_state_t              state, state_nx;
    logic [IW-1:0]           idx;
    logic                    st_r, vec_r;
    logic [ADDR_W-1:0]       base_r;
    logic                    accept, beat, last;
    logic [LANES*WORD_W-1:0] st_init, st_q, ld_q;

    assign accept  = (state == IDLE) && start;
    assign beat    = (state == ACCESS) && mem_ready;
    assign last    = vec_r ? (idx == IW'(LANES - 1)) : (idx == '0);
    // Scalar store data rides in lane 0 so the same lane path serves both kinds.
    assign st_init = is_vector ? store_vec : {{((LANES-1)*WORD_W){1'b0}}, store_word};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = ACCESS;
            ACCESS:  if (beat && last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= '0;
            st_r   <= 1'b0;
            vec_r  <= 1'b0;
            base_r <= '0;
        end else if (accept) begin
            idx    <= '0;
            st_r   <= is_store;
            vec_r  <= is_vector;
            base_r <= addr & ~ADDR_W'(3);
        end else if (beat) begin
            idx    <= idx + 1'b1;
        end
    end

    vlane_gather u_store_data (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_all  (accept && is_store),
        .load_data (st_init),
        .lane_we   (1'b0),
        .lane_idx  (idx),
        .lane_data ('0),
        .q         (st_q)
    );

    // Lanes are written only by accepted load beats, so stores leave results intact.
    vlane_gather u_load_data (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_all  (1'b0),
        .load_data ('0),
        .lane_we   (beat && !st_r),
        .lane_idx  (idx),
        .lane_data (mem_rdata),
        .q         (ld_q)
    );

    // Everything below decodes registered state only; start never reaches an output.
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign mem_req   = (state == ACCESS);
    assign mem_we    = mem_req && st_r;
    assign mem_addr  = base_r + ADDR_W'({idx, 2'b00});
    assign mem_wdata = lane_sel(st_q, idx);
    assign load_vec  = ld_q;
    assign load_word = ld_q[WORD_W-1:0];

endmodule

// File: tb/tb_vector_mem_unit.sv
// tb/tb_vector_mem_unit.sv - self-checking bench for vector_mem_unit
module tb_vector_mem_unit;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         is_store = 1'b0;
    logic         is_vector = 1'b0;
    logic [31:0]  addr = '0;
    logic [255:0] store_vec = '0;
    logic [31:0]  store_word = '0;
    logic         busy, done, mem_req, mem_we;
    logic [255:0] load_vec;
    logic [31:0]  load_word, mem_addr, mem_wdata, mem_rdata;
    logic         mem_ready = 1'b1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        st;
        logic        vec;
        logic [31:0] addr;
        logic [31:0] seed;
        logic [31:0] base;
    } txn_t;

    txn_t tbl [6];

    always #5 clk = ~clk;

    // Memory model: word read data depends on address bits [4:2] only.
    assign mem_rdata = 32'hA0 + {29'd0, mem_addr[4:2]};

    vector_mem_unit #(.LANES(8), .WORD_W(32), .ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .is_store   (is_store),
        .is_vector  (is_vector),
        .addr       (addr),
        .store_vec  (store_vec),
        .store_word (store_word),
        .busy       (busy),
        .done       (done),
        .load_vec   (load_vec),
        .load_word  (load_word),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        return 32'hA0 + {29'd0, a[4:2]};
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called just after a falling edge; start is sampled at the next rising edge
    // (edge 0), then the request inputs are scrambled to prove they were captured.
    task automatic do_start(input logic st, input logic vec, input logic [31:0] a,
                            input logic [255:0] sv, input logic [31:0] sw);
        is_store   = st;
        is_vector  = vec;
        addr       = a;
        store_vec  = sv;
        store_word = sw;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        is_store   = ~st;
        is_vector  = ~vec;
        addr       = 32'h5A5A_5A5A;
        store_vec  = {8{32'h0BAD_F00D}};
        store_word = 32'h0BAD_F00D;
    endtask

    initial begin
        logic [255:0] exp_lv;
        logic [255:0] sv;
        logic [31:0]  sw;
        logic [31:0]  a;
        int           n, nreq, ndone;

        tbl[0] = '{1'b1, 1'b1, 32'h0000_0100, 32'h1111_1111, 32'h0000_0100};
        tbl[1] = '{1'b0, 1'b1, 32'h0000_0203, 32'h0000_0000, 32'h0000_0200};
        tbl[2] = '{1'b0, 1'b1, 32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFF8};
        tbl[3] = '{1'b1, 1'b0, 32'h0000_4002, 32'hDEAD_BEEF, 32'h0000_4000};
        tbl[4] = '{1'b0, 1'b0, 32'h0000_0037, 32'h0000_0000, 32'h0000_0034};
        tbl[5] = '{1'b1, 1'b1, 32'hFFFF_FFF0, 32'h0101_0101, 32'hFFFF_FFF0};

        repeat (3) @(negedge clk);
        chk("rst busy",      busy,      0);
        chk("rst done",      done,      0);
        chk("rst mem_req",   mem_req,   0);
        chk("rst mem_we",    mem_we,    0);
        chk("rst mem_addr",  mem_addr,  0);
        chk("rst mem_wdata", mem_wdata, 0);
        chk("rst load_vec",  load_vec,  0);
        chk("rst load_word", load_word, 0);
        rst_n = 1'b1;
        @(negedge clk);
        exp_lv = '0;

        // Table: back-to-back transactions with mem_ready held high.
        for (int t = 0; t < 6; t++) begin
            n = tbl[t].vec ? 8 : 1;
            for (int i = 0; i < 8; i++) sv[i*32 +: 32] = tbl[t].seed * 32'(i + 1);
            if (!tbl[t].vec) sv = {8{~tbl[t].seed}};
            sw = tbl[t].vec ? ~tbl[t].seed : tbl[t].seed;
            do_start(tbl[t].st, tbl[t].vec, tbl[t].addr, sv, sw);
            for (int c = 1; c <= n; c++) begin
                @(negedge clk);
                a = tbl[t].base + 32'(4 * (c - 1));
                chk($sformatf("t%0d c%0d mem_req", t, c),  mem_req,  1);
                chk($sformatf("t%0d c%0d mem_we", t, c),   mem_we,   tbl[t].st);
                chk($sformatf("t%0d c%0d mem_addr", t, c), mem_addr, a);
                chk($sformatf("t%0d c%0d done", t, c),     done,     0);
                if (tbl[t].st)
                    chk($sformatf("t%0d c%0d mem_wdata", t, c), mem_wdata, tbl[t].seed * 32'(c));
                else
                    exp_lv[(c-1)*32 +: 32] = exp_rd(a);
            end
            @(negedge clk);
            chk($sformatf("t%0d done pulse", t), done,      1);
            chk($sformatf("t%0d done busy", t),  busy,      1);
            chk($sformatf("t%0d done req", t),   mem_req,   0);
            chk($sformatf("t%0d load_vec", t),   load_vec,  exp_lv);
            chk($sformatf("t%0d load_word", t),  load_word, exp_lv[31:0]);
            @(negedge clk);
            chk($sformatf("t%0d idle busy", t),  busy,      0);
            chk($sformatf("t%0d idle done", t),  done,      0);
        end

        // Scalar store stalled by mem_ready low in cycles 1-3.
        mem_ready = 1'b0;
        do_start(1'b1, 1'b0, 32'h0000_1006, {8{32'h1234_5678}}, 32'hCAFE_F00D);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk($sformatf("stall c%0d req", c),   mem_req,   1);
            chk($sformatf("stall c%0d we", c),    mem_we,    1);
            chk($sformatf("stall c%0d addr", c),  mem_addr,  32'h0000_1004);
            chk($sformatf("stall c%0d wdata", c), mem_wdata, 32'hCAFE_F00D);
            chk($sformatf("stall c%0d done", c),  done,      0);
            if (c == 4) mem_ready = 1'b1;
        end
        @(negedge clk);
        chk("stall done c5", done, 1);
        chk("stall load kept", load_vec, exp_lv);
        @(negedge clk);
        chk("stall idle c6", busy, 0);

        // start pulses during ACCESS (edge 3) and DONE (edge 9) must be ignored.
        for (int i = 0; i < 8; i++) sv[i*32 +: 32] = 32'h0202_0202 * 32'(i + 1);
        do_start(1'b1, 1'b1, 32'h0000_0300, sv, 32'h0);
        nreq  = 0;
        ndone = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (mem_req) nreq++;
            if (done) ndone++;
            if (c == 4) chk("ign addr c4", mem_addr, 32'h0000_030C);
            if (c == 9) chk("ign done c9", done, 1);
            if (c == 3 || c == 9) begin
                is_store  = 1'b0;
                is_vector = 1'b0;
                addr      = 32'h0000_0999;
                start     = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        chk("ign req count",  32'(nreq),  32'd8);
        chk("ign done count", 32'(ndone), 32'd1);
        chk("ign final busy", busy, 0);

        // Reset in cycle 4 of a vector store, then a scalar load.
        do_start(1'b1, 1'b1, 32'h0000_0400, sv, 32'h0);
        repeat (4) @(negedge clk);
        chk("rst4 req before", mem_req, 1);
        rst_n = 1'b0;
        #1;
        chk("rst4 req",  mem_req,  0);
        chk("rst4 busy", busy,     0);
        chk("rst4 done", done,     0);
        chk("rst4 load_vec", load_vec, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        exp_lv = '0;
        do_start(1'b0, 1'b0, 32'h0000_0050, sv, 32'h0);
        @(negedge clk);
        chk("post req",  mem_req,  1);
        chk("post we",   mem_we,   0);
        chk("post addr", mem_addr, 32'h0000_0050);
        @(negedge clk);
        exp_lv[31:0] = 32'h0000_00A4;
        chk("post done",      done,      1);
        chk("post load_word", load_word, 32'h0000_00A4);
        chk("post load_vec",  load_vec,  exp_lv);
        @(negedge clk);
        chk("post idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vector_mem_unit.md
# vector_mem_unit

Memory-stage access unit that consumes the execute stage's results (address from the scalar ALU result, store data from the vector ALU result or the scalar write-data path). It serializes 256-bit vector stores into eight 32-bit word writes. It gathers eight 32-bit word reads back into a 256-bit vector for loads. Scalar loads and stores are handled as single-word accesses. It stalls the pipeline through `busy` until the access completes.

## Interface
Parameters:
- `LANES`, 8, number of 32-bit lanes per vector
- `WORD_W`, 32, lane / memory word width
- `ADDR_W`, 32, byte address width

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request pulse; accepted only when `busy`=0
- `is_store`  in  1  1 = store, 0 = load; sampled at accepted `start`
- `is_vector`  in  1  1 = `LANES`-word access, 0 = single word; sampled at accepted `start`
- `addr`  in  ADDR_W  base byte address (execute ALU result)
- `store_vec`  in  LANES*WORD_W  vector store data; lane 0 = bits [31:0]
- `store_word`  in  WORD_W  scalar store data
- `busy`  out  1  pipeline stall; high whenever state ≠ IDLE
- `done`  out  1  one-cycle completion pulse
- `load_vec`  out  LANES*WORD_W  gathered vector load result
- `load_word`  out  WORD_W  scalar load result
- `mem_req`  out  1  memory request valid
- `mem_we`  out  1  write enable; qualified by `mem_req`
- `mem_addr`  out  ADDR_W  word-aligned byte address
- `mem_wdata`  out  WORD_W  write data
- `mem_ready`  in  1  memory accepts the current request this cycle
- `mem_rdata`  in  WORD_W  read data; valid in the cycle `mem_req && !mem_we && mem_ready`

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE → ACCESS on `start`:
  - Capture `is_store`, `is_vector`, and `addr` with bits [1:0] forced to 0.
  - Capture `store_vec` or `store_word` into a 256-bit data register (scalar in lane 0).
  - Clear the lane counter `idx` (3 bits).
- ACCESS:
  - `mem_req`=1, `mem_we`=captured `is_store`, `mem_addr`=base + 4·`idx`, `mem_wdata`=lane `idx` of the data register.
  - On `mem_ready`: a load writes `mem_rdata` into lane `idx` of the load register, and `idx` increments.
  - Last lane is `idx`=LANES−1 for vector and `idx`=0 for scalar. When the last lane is accepted, go to DONE.
  - Without `mem_ready`, all request outputs hold stable; there is no timeout.
- DONE: `done`=1 for exactly one cycle, `mem_req`=0, then → IDLE.
- `load_vec` and `load_word` update only during loads. `load_word` = lane 0 of the load register. Both hold their value until the next load writes them; stores leave them untouched.
- `start` while `busy`=1 (ACCESS or DONE) is ignored, not queued.
- Address arithmetic is modulo 2^ADDR_W; wrap-around past 0xFFFFFFFC continues at 0x00000000.
- `addr` and store data may change after the accepting edge without effect.
- Asserting `rst_n` low at any time returns to IDLE immediately, drops `mem_req`, and abandons any partial transfer.

## Timing
- Reset values: `busy`=0, `done`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `load_vec`=0, `load_word`=0; state IDLE, `idx`=0.
- All outputs are registered or decoded from registered state; no combinational path from `start` to any output.
- `start` sampled at edge 0 → `mem_req` high from cycle 1.
- With `mem_ready` held high:
  - Vector: accesses in cycles 1–8, `done` in cycle 9, `busy` falls in cycle 10. Total latency 9 cycles.
  - Scalar: access in cycle 1, `done` in cycle 2.
- Each cycle with `mem_ready`=0 in ACCESS adds one cycle of latency.
- `load_vec`/`load_word` are valid no later than the `done` cycle.
- Back-to-back throughput: a new `start` can be accepted in the first cycle after DONE.

## Structure
- Shared package `mem_pkg`:
  - State enum `mem_state_t` {IDLE, ACCESS, DONE}.
  - Constants `LANES`=8, `WORD_W`=32, `VEC_W`=256.
  - Lane-select helper: function returning word `i` of a 256-bit vector.
- One sub-module, `vlane_gather`: 256-bit register with per-lane write enable (`lane_idx`, `lane_we`, `lane_data`). It is instantiated twice, once for store data and once for load assembly.

## Test plan
- Vector store, `addr`=0x100, `store_vec` lanes = 0x11111111·(i+1), `mem_ready`=1 → writes to 0x100..0x11C with lane i data in cycles 1–8; `done` in cycle 9.
- Vector load, `addr`=0x203 (misaligned), memory returns 0xA0+i → `mem_addr` sequence 0x200..0x21C; `load_vec` lane i = 0xA0+i at `done`.
- Scalar store with `mem_ready` low for 3 cycles → `mem_addr`/`mem_wdata`/`mem_we` stable throughout; `done` in cycle 5.
- `start` pulsed during ACCESS and during DONE → ignored; exactly one `done` pulse; no extra `mem_req`.
- Vector load at `addr`=0xFFFFFFF8 → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0..0x14 (wrap).
- `rst_n` low in cycle 4 of a vector store → `mem_req`, `busy`, `done` at 0 immediately. After release, a new scalar load completes normally with `done` in cycle 2.
